ti_sbox_sched: RTL
==================

Name: ti_sbox_sched

Overview:
- Scheduler for the shared, pipelined 2-share TI S-box bank (tower-field GF(2^4)/GF(2^2) inversion, registered stages) in the masked AES core.
- Arbitrates the bank between two requesters: the data path (SubBytes, several column issues) and the key schedule (SubWord, one issue).
- Issues operands, gates pipeline advance on fresh-randomness availability, tracks in-flight operands and signals write-back and job completion.

Parameters:
- LAT, 4, S-box pipeline depth in enabled cycles, issue to result; range 1..8.
- N_DATA, 4, column issues per data job (16 bytes / 4 S-box instances).
- CW, 2, column counter width; must satisfy 2^CW >= N_DATA.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- d_req  in  1  data job request, level; held until d_done.
- d_ack  out  1  one-cycle pulse: data job granted.
- d_done  out  1  one-cycle pulse: last data result written back.
- k_req  in  1  key job request, level; held until k_done.
- k_ack  out  1  one-cycle pulse: key job granted.
- k_done  out  1  one-cycle pulse: key result written back.
- rnd_vld  in  1  fresh mask randomness available this cycle.
- sb_en  out  1  S-box pipeline register enable.
- sb_issue  out  1  operand enters the S-box this cycle.
- sb_col  out  CW  column index of the issued operand.
- sb_src  out  1  operand mux select: 0 = data state, 1 = key word.
- wb_vld  out  1  S-box output valid; destination must capture it.
- wb_col  out  CW  column index of the written-back result.
- wb_src  out  1  destination of the written-back result: 0 = data, 1 = key.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: every output is 0. State goes to IDLE, the column counter clears, the in-flight tag pipeline clears, and the priority flag is set to key-first.
- RST asserted mid-job: all in-flight operands are discarded. No done pulse is produced, and no acknowledgement follows for the aborted job.
- States:
  - IDLE: on each edge, sample the requests. If both are high, grant the requester named by the priority flag; otherwise grant the one that is high. The next cycle is ISSUE with the matching ack pulse, counter = 0, sb_src = the granted source.
  - ISSUE: sb_issue = rnd_vld and sb_col = counter; the counter increments on each issue. After issue N_DATA-1 (data) or issue 0 (key), move to DRAIN.
  - DRAIN: wait for the final write-back, then return to IDLE in the same edge that produces the done pulse.
- sb_en = rnd_vld & busy. The pipeline advances only on enabled cycles, including in DRAIN, because every TI stage consumes fresh randomness.
- Tag pipeline: LAT entries of {valid, col, src}. The head loads {sb_issue, sb_col, sb_src} and the pipeline shifts when sb_en is high.
  - wb_vld = tail valid & sb_en, with wb_col and wb_src taken from the tail entry.
- Done: d_done or k_done pulses in the same cycle as the last wb_vld of the job. The priority flag then toggles to favour the other requester.
- Latency: with rnd_vld held at 1 and LAT = 4, N_DATA = 4:
  - d_ack at cycle 1, issues at cycles 1..4, wb_vld at cycles 5..8, d_done at cycle 8;
  - key job: ack at 1, wb and done at 5.
- Jobs are non-preemptive. A request arriving mid-job waits in IDLE arbitration. A request still high in the cycle after done is treated as a new job and is granted on the next edge.
- Requests dropped before ack are ignored; there is no memory of them.
- rnd_vld low: no issue, no shift, no wb_vld; the counter holds. Stall length is unbounded.

Optional Feature:
- Macro TI_SCHED_BUBBLE_EN.
- Defined: after each issue, the next enabled cycle issues nothing. This inserts a bubble and keeps share-dependent operands of consecutive columns out of adjacent stages (glitch/coupling isolation).
  - Data-job issues occur on enabled cycles 1, 3, 5, 7; with rnd_vld = 1 and LAT = 4, d_done at cycle 11. Key jobs are unchanged.
- Undefined: back-to-back issue as described above.

Test Plan:
- Data job alone, rnd_vld = 1, LAT = 4 -> d_ack cycle 1; sb_col 0,1,2,3 at cycles 1–4; wb_col 0..3 at 5–8; d_done at 8; busy low at 9.
- d_req and k_req rise together from reset -> key granted first (k_done at 5), data granted at cycle 7 after IDLE re-arbitration; a second simultaneous request afterwards is granted to key.
- Data job with rnd_vld = 0 at cycles 2 and 6 -> issues at 1, 3, 4, 5; d_done delayed to cycle 10; no wb_vld while rnd_vld = 0.
- RST pulsed at cycle 4 of a data job -> all outputs 0 at cycle 5; no d_done; a new d_req is granted normally.
- k_req held high across k_done -> second k_ack two cycles after the first k_done, with wb_src = 1 for both results.
- TI_SCHED_BUBBLE_EN defined, data job, rnd_vld = 1 -> sb_issue at cycles 1, 3, 5, 7; d_done at cycle 11.

Source files
------------

// File: rtl/ti_sbox_sched.sv
// Issue/drain scheduler for the shared pipelined 2-share TI S-box bank (data SubBytes vs key SubWord).
// Optional: define TI_SCHED_BUBBLE_EN to leave an idle enabled cycle after every issue.
module ti_sbox_sched #(
  parameter int LAT    = 4,
  parameter int N_DATA = 4,
  parameter int CW     = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          d_req,
  output logic          d_ack,
  output logic          d_done,
  input  logic          k_req,
  output logic          k_ack,
  output logic          k_done,
  input  logic          rnd_vld,
  output logic          sb_en,
  output logic          sb_issue,
  output logic [CW-1:0] sb_col,
  output logic          sb_src,
  output logic          wb_vld,
  output logic [CW-1:0] wb_col,
  output logic          wb_src,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_COL = CW'(N_DATA - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          src;
  logic          prio_key;

  logic          tag_v [LAT];
  logic [CW-1:0] tag_c [LAT];
  logic          tag_s [LAT];

  logic early_v;
  logic last_issue;
  logic last_wb;
  logic grant_k;
  logic grant_d;

  // Handshake: d_req/k_req are levels held until the matching done; d_ack/k_ack
  // and d_done/k_done are single-cycle pulses; wb_vld is a one-cycle strobe the
  // destination must capture with no back-pressure.
  assign busy      = (state != IDLE);
  assign sb_en     = rnd_vld & busy;
  assign sb_col    = cnt;
  assign sb_src    = src;
  assign dbg_state = state;

`ifdef TI_SCHED_BUBBLE_EN
  logic bub;

  assign sb_issue = (state == ISSUE) & rnd_vld & ~bub;

  // Keeps operands of consecutive columns out of adjacent TI stages.
  always_ff @(posedge CLK) begin
    if (RST)           bub <= 1'b0;
    else if (sb_issue) bub <= 1'b1;
    else if (sb_en)    bub <= 1'b0;
  end
`else
  assign sb_issue = (state == ISSUE) & rnd_vld;
`endif

  assign wb_vld = tag_v[LAT-1] & sb_en;
  assign wb_col = tag_c[LAT-1];
  assign wb_src = tag_s[LAT-1];

  always_comb begin
    early_v = 1'b0;
    for (int i = 0; i < LAT - 1; i++) early_v = early_v | tag_v[i];
  end

  assign last_issue = sb_issue & (src | (cnt == LAST_COL));
  // In DRAIN nothing new enters, so a write-back with an empty upstream is the job's last.
  assign last_wb    = wb_vld & (state == DRAIN) & ~early_v;
  assign d_done     = last_wb & ~src;
  assign k_done     = last_wb & src;

  assign grant_k = k_req & (prio_key | ~d_req);
  assign grant_d = d_req & ~grant_k;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      src      <= 1'b0;
      prio_key <= 1'b1;
      d_ack    <= 1'b0;
      k_ack    <= 1'b0;
    end else begin
      d_ack <= 1'b0;
      k_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_k | grant_d) begin
            state <= ISSUE;
            cnt   <= '0;
            src   <= grant_k;
            k_ack <= grant_k;
            d_ack <= grant_d;
          end
        end
        ISSUE: begin
          if (sb_issue) begin
            cnt <= cnt + 1'b1;
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_wb) begin
            state    <= IDLE;
            prio_key <= ~src;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < LAT; i++) begin
        tag_v[i] <= 1'b0;
        tag_c[i] <= '0;
        tag_s[i] <= 1'b0;
      end
    end else if (sb_en) begin
      tag_v[0] <= sb_issue;
      tag_c[0] <= sb_col;
      tag_s[0] <= sb_src;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_c[i] <= tag_c[i-1];
        tag_s[i] <= tag_s[i-1];
      end
    end
  end

endmodule
